// File: rtl/led_pattern_gen.sv
// led_pattern_gen: LED pattern engine for the board LEDs.
//
// A prescaler divides clk down to a one-cycle step strobe. On each strobe a small
// pattern state machine advances whichever of four patterns is currently selected.
// A free-running PWM stage gates the pattern to dim the lit LEDs.
//
// Ports:
//   clk       system clock
//   resetn    asynchronous active-low reset
//   en        1 = prescaler runs, 0 = prescaler and pattern frozen (PWM keeps running)
//   mode      pattern select (00 count, 01 bounce, 10 fill, 11 hold), sampled on step_stb
//   duty      PWM brightness, sampled when the PWM counter wraps
//   led       registered LED drive, 1 = lit
//   step_stb  one-cycle pulse on the cycle the pattern advances

module led_pattern_gen #(
    parameter int unsigned PRESCALE = 900000,
    parameter int unsigned NLED     = 5,
    parameter int unsigned PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic [PWM_BITS-1:0] duty,
    output logic [NLED-1:0]     led,
    output logic                step_stb
);

    localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned PosW = $clog2(NLED);
    localparam int unsigned LvlW = $clog2(NLED + 1);

    localparam logic [PreW-1:0]     PreMax  = PreW'(PRESCALE - 1);
    localparam logic [PosW-1:0]     PosMax  = PosW'(NLED - 1);
    localparam logic [LvlW-1:0]     LvlMax  = LvlW'(NLED);
    localparam logic [NLED-1:0]     OneLed  = NLED'(1);
    localparam logic [PWM_BITS-1:0] PwmMax  = '1;

    typedef enum logic [1:0] {
        ModeCount  = 2'b00,
        ModeBounce = 2'b01,
        ModeFill   = 2'b10,
        ModeHold   = 2'b11
    } mode_e;

    typedef enum logic {
        DirUp   = 1'b0,
        DirDown = 1'b1
    } dir_e;

    // ------------------------------------------------------------------
    // Prescaler and step strobe
    // ------------------------------------------------------------------
    logic [PreW-1:0] presc_q, presc_d;
    logic            wrap;
    logic            stb_q;

    always_comb begin
        wrap    = en && (presc_q == PreMax);
        presc_d = presc_q;
        if (en) begin
            presc_d = wrap ? '0 : presc_q + 1'b1;
        end
    end

    // The strobe is registered from the wrap cycle, so once a wrap has been seen
    // the step is taken even if en drops on the strobe cycle itself.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc_q <= '0;
            stb_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            stb_q   <= wrap;
        end
    end

    assign step_stb = stb_q;

    // ------------------------------------------------------------------
    // Pattern state machine
    // ------------------------------------------------------------------
    mode_e            mode_q, mode_d;
    dir_e             dir_q, dir_d;
    logic [NLED-1:0]  count_q, count_d;
    logic [PosW-1:0]  pos_q, pos_d;
    logic [LvlW-1:0]  level_q, level_d;
    logic [NLED-1:0]  hold_pat_q, hold_pat_d;
    logic [NLED-1:0]  pat;

    // The step is taken for the mode that was active up to this strobe; the newly
    // sampled mode only shows its own (retained) state from here on.
    always_comb begin
        mode_d  = mode_q;
        dir_d   = dir_q;
        count_d = count_q;
        pos_d   = pos_q;
        level_d = level_q;
        if (stb_q) begin
            mode_d = mode_e'(mode);
            unique case (mode_q)
                ModeCount: begin
                    count_d = count_q + 1'b1;
                end
                ModeBounce: begin
                    if (dir_q == DirUp) begin
                        pos_d = pos_q + 1'b1;
                        if (pos_d == PosMax) begin
                            dir_d = DirDown;
                        end
                    end else begin
                        pos_d = pos_q - 1'b1;
                        if (pos_d == '0) begin
                            dir_d = DirUp;
                        end
                    end
                end
                ModeFill: begin
                    level_d = (level_q == LvlMax) ? '0 : level_q + 1'b1;
                end
                ModeHold: begin
                end
            endcase
        end
    end

    always_comb begin
        pat = '0;
        unique case (mode_q)
            ModeCount:  pat = count_q;
            ModeBounce: pat = OneLed << pos_q;
            ModeFill: begin
                for (int unsigned i = 0; i < NLED; i++) begin
                    pat[i] = (LvlW'(i) < level_q);
                end
            end
            ModeHold:   pat = hold_pat_q;
        endcase
    end

    // Track the displayed pattern while not holding, so hold freezes whatever was
    // visible just before it took over.
    always_comb begin
        hold_pat_d = hold_pat_q;
        if (mode_q != ModeHold) begin
            hold_pat_d = pat;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mode_q     <= ModeCount;
            dir_q      <= DirUp;
            count_q    <= '0;
            pos_q      <= '0;
            level_q    <= '0;
            hold_pat_q <= '0;
        end else begin
            mode_q     <= mode_d;
            dir_q      <= dir_d;
            count_q    <= count_d;
            pos_q      <= pos_d;
            level_q    <= level_d;
            hold_pat_q <= hold_pat_d;
        end
    end

    // ------------------------------------------------------------------
    // PWM and output register
    // ------------------------------------------------------------------
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                lit;
    logic [NLED-1:0]     led_d;
    logic [NLED-1:0]     led_q;

    always_comb begin
        // Duty only changes at the period boundary to avoid mid-period glitches.
        duty_d = duty_q;
        if (pwm_cnt_q == PwmMax) begin
            duty_d = duty;
        end
        // All-ones duty is forced fully on rather than dropping one slot per period.
        lit   = (pwm_cnt_q < duty_q) || (duty_q == PwmMax);
        led_d = pat & {NLED{lit}};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pwm_cnt_q <= '0;
            duty_q    <= '0;
            led_q     <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
            duty_q    <= duty_d;
            led_q     <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen (PRESCALE=4, NLED=5, PWM_BITS=4).
module tb_led_pattern_gen;

    localparam int unsigned PRESCALE = 4;
    localparam int unsigned NLED     = 5;
    localparam int unsigned PWM_BITS = 4;

    logic                clk = 1'b0;
    logic                resetn;
    logic                en;
    logic [1:0]          mode;
    logic [PWM_BITS-1:0] duty;
    logic [NLED-1:0]     led;
    logic                step_stb;

    always #5 clk = ~clk;

    led_pattern_gen #(
        .PRESCALE (PRESCALE),
        .NLED     (NLED),
        .PWM_BITS (PWM_BITS)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .en       (en),
        .mode     (mode),
        .duty     (duty),
        .led      (led),
        .step_stb (step_stb)
    );

    // Bench time base: absolute cycle count and the PWM phase since reset release.
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [3:0] phase;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) phase <= 4'd0;
        else         phase <= phase + 4'd1;
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [NLED-1:0] exp_q[$];
    int unsigned last_stb = 0;

    typedef struct packed {
        logic [1:0]      mode;
        logic [NLED-1:0] exp;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [1:0] m, input logic [NLED-1:0] e);
        vec_t v;
        v.mode = m;
        v.exp  = e;
        vecs.push_back(v);
    endtask

    // Advance to the next negedge at which step_stb is high, bounded.
    task automatic wait_stb(input string name, output int unsigned spacing);
        bit seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (step_stb === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no step_stb within 64 cycles", name);
            spacing = 0;
        end else begin
            spacing  = cyc - last_stb;
            last_stb = cyc;
        end
    endtask

    // One pattern step: expected LED pushed now, compared once the DUT shows it
    // (strobe cycle -> state update -> registered led).
    task automatic step_check(input string name, input logic [NLED-1:0] exp,
                              input bit chk_space, input int unsigned exp_space);
        int unsigned sp;
        exp_q.push_back(exp);
        wait_stb(name, sp);
        if (chk_space) check({name, " spacing"}, sp, exp_space);
        @(negedge clk);
        check({name, " pulse width"}, {31'd0, step_stb}, 32'd0);
        @(negedge clk);
        check(name, {27'd0, led}, {27'd0, exp_q.pop_front()});
    endtask

    // Check led for n consecutive cycles against the PWM window of duty d.
    task automatic pwm_span(input string name, input int d, input int n, inout int highs);
        logic [NLED-1:0] e;
        for (int k = 0; k < n; k++) begin
            if (k != 0) @(negedge clk);
            // led at this negedge reflects the counter value one cycle earlier.
            e = ((phase >= 4'd1) && (int'(phase) <= d)) ? 5'b11111 : 5'b00000;
            check($sformatf("%s phase%0d", name, phase), {27'd0, led}, {27'd0, e});
            if (led === 5'b11111) highs++;
        end
    endtask

    task automatic wait_phase0();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (phase == 4'd0 && i > 0) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL wait_phase0: phase never returned to 0");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int highs;
        int cnt;
        int unsigned sp;

        // Bounce, fill, then hold frozen on 00011.
        add_vec(2'b01, 5'b00001);
        add_vec(2'b01, 5'b00010);
        add_vec(2'b01, 5'b00100);
        add_vec(2'b01, 5'b01000);
        add_vec(2'b01, 5'b10000);
        add_vec(2'b01, 5'b01000);
        add_vec(2'b01, 5'b00100);
        add_vec(2'b01, 5'b00010);
        add_vec(2'b01, 5'b00001);
        add_vec(2'b01, 5'b00010);
        add_vec(2'b10, 5'b00000);
        add_vec(2'b10, 5'b00001);
        add_vec(2'b10, 5'b00011);
        add_vec(2'b10, 5'b00111);
        add_vec(2'b10, 5'b01111);
        add_vec(2'b10, 5'b11111);
        add_vec(2'b10, 5'b00000);
        add_vec(2'b10, 5'b00001);
        add_vec(2'b10, 5'b00011);
        for (int i = 0; i < 10; i++) add_vec(2'b11, 5'b00011);

        resetn = 1'b0;
        en     = 1'b0;
        mode   = 2'b00;
        duty   = 4'd15;
        repeat (3) @(negedge clk);
        check("reset led", {27'd0, led}, 32'd0);
        check("reset step_stb", {31'd0, step_stb}, 32'd0);
        resetn = 1'b1;

        // Let duty load with the prescaler frozen.
        repeat (20) @(negedge clk);
        check("idle led", {27'd0, led}, 32'd0);
        check("idle step_stb", {31'd0, step_stb}, 32'd0);

        // Test 1: counting, wrap after 32 steps.
        en = 1'b1;
        last_stb = cyc;
        for (int i = 0; i < 32; i++) begin
            step_check($sformatf("count%0d", i), NLED'((i + 1) % 32), 1'b1, PRESCALE);
        end

        // Tests 2-3: table-driven bounce / fill / hold.
        foreach (vecs[i]) begin
            mode = vecs[i].mode;
            step_check($sformatf("vec%0d mode%0d", i, vecs[i].mode), vecs[i].exp, 1'b1, PRESCALE);
        end

        // Test 4: duty 0 keeps everything dark in all patterns.
        duty = 4'd0;
        repeat (20) @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            mode = (i < 3) ? 2'b00 : (i < 6) ? 2'b01 : 2'b10;
            step_check($sformatf("dark%0d", i), 5'b00000, i != 0, PRESCALE);
        end

        // Test 5: freeze on fill=11111, dim with duty 4, then change duty mid-period.
        en   = 1'b0;
        duty = 4'd4;
        wait_phase0();
        highs = 0;
        pwm_span("pwm d4", 4, 16, highs);
        check("pwm d4 on-count", highs, 4);
        @(negedge clk);
        highs = 0;
        pwm_span("pwm d4 pre", 4, 7, highs);
        duty = 4'd8;
        @(negedge clk);
        pwm_span("pwm d4 tail", 4, 9, highs);
        check("pwm d4 period on-count", highs, 4);
        @(negedge clk);
        highs = 0;
        pwm_span("pwm d8", 8, 16, highs);
        check("pwm d8 on-count", highs, 8);

        // Test 6: en pulse stretches spacing.
        duty = 4'd15;
        mode = 2'b00;
        repeat (20) @(negedge clk);
        en = 1'b1;
        step_check("resume A", 5'b00100, 1'b0, 0);
        step_check("resume B", 5'b00101, 1'b1, PRESCALE);
        en = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b1;
        step_check("en pulse C", 5'b00110, 1'b1, PRESCALE + 3);
        step_check("en pulse D", 5'b00111, 1'b1, PRESCALE);

        // en falls on the strobe cycle: the step still happens, then nothing more.
        @(negedge clk);
        @(negedge clk);
        check("en fall strobe", {31'd0, step_stb}, 32'd1);
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("en fall step", {27'd0, led}, {27'd0, 5'b01000});
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (step_stb === 1'b1) cnt++;
        end
        check("en low no strobe", cnt, 0);

        // Asynchronous reset mid-step.
        en = 1'b1;
        wait_stb("pre-reset strobe", sp);
        check("pre-reset led", {27'd0, led}, {27'd0, 5'b01000});
        #2 resetn = 1'b0;
        #1;
        check("async reset led", {27'd0, led}, 32'd0);
        check("async reset step_stb", {31'd0, step_stb}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        last_stb = cyc;
        wait_stb("post-reset strobe", sp);
        check("post-reset first strobe", sp, PRESCALE);
        check("post-reset led", {27'd0, led}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
